// File: rtl/gray_step_monitor_if.sv
// Sample stream from the gray counter stage into the step monitor.
// The master drives samples and the slave consumes them.
interface gray_step_monitor_if #(
    parameter int CBITS = 16
) ();
    logic             in_valid;
    logic [CBITS-1:0] gray_in;

    modport master (output in_valid, output gray_in);
    modport slave  (input  in_valid, input  gray_in);
endinterface

// File: rtl/gray_step_monitor.sv
// Decodes gray samples to binary and checks that successive samples advance by exactly one count.
// It reports wraps and step errors, and tracks lock status with a relock hysteresis.
module gray_step_monitor #(
    parameter int CBITS     = 16,
    parameter int WRAP_BITS = 8,
    parameter int RELOCK    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_step_monitor_if.slave    sif,
    output logic [CBITS-1:0]      bin_out,
    output logic                  bin_valid,
    output logic                  wrap_pulse,
    output logic [WRAP_BITS-1:0]  wrap_cnt,
    output logic                  step_err,
    output logic [7:0]            err_cnt,
    output logic                  locked
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    function automatic logic [CBITS-1:0] gray2bin(input logic [CBITS-1:0] g);
        logic [CBITS-1:0] b;
        b = '0;
        b[CBITS-1] = g[CBITS-1];
        for (int i = CBITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state;
    logic [CBITS-1:0] prev;
    logic [3:0]       good_run;

    logic [CBITS-1:0] bin_p0;
    logic             is_dup_p0;
    logic             is_good_p0;
    logic             prev_ones_p0;
    logic             relock_p0;

    // Stage p0: combinational decode and step classification against prev
    always_comb begin
        bin_p0       = gray2bin(sif.gray_in);
        is_dup_p0    = (bin_p0 == prev);
        is_good_p0   = (bin_p0 == CBITS'(prev + CBITS'(1)));
        prev_ones_p0 = &prev;
        relock_p0    = (4'(good_run + 4'd1) == 4'(RELOCK));
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SYNC;
            prev       <= '0;
            good_run   <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            err_cnt    <= '0;
            locked     <= 1'b0;
        end else begin
            bin_valid  <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            if (sif.in_valid) begin
                bin_valid <= 1'b1;
                unique case (state)
                    SYNC: begin
                        prev    <= bin_p0;
                        bin_out <= bin_p0;
                        state   <= LOCKED;
                        locked  <= 1'b1;
                    end
                    LOCKED: begin
                        if (is_dup_p0) begin
                            // A repeated sample is an upstream stall, not an error.
                        end else if (is_good_p0) begin
                            prev    <= bin_p0;
                            bin_out <= bin_p0;
                            if (prev_ones_p0) begin
                                wrap_pulse <= 1'b1;
                                wrap_cnt   <= wrap_cnt + WRAP_BITS'(1);
                            end
                        end else begin
                            prev     <= bin_p0;
                            bin_out  <= bin_p0;
                            step_err <= 1'b1;
                            err_cnt  <= sat_inc8(err_cnt);
                            good_run <= '0;
                            state    <= FAULT;
                            locked   <= 1'b0;
                        end
                    end
                    FAULT: begin
                        if (is_dup_p0) begin
                            // Stall: good_run is neither advanced nor cleared.
                        end else if (is_good_p0) begin
                            prev    <= bin_p0;
                            bin_out <= bin_p0;
                            if (relock_p0) begin
                                good_run <= '0;
                                state    <= LOCKED;
                                locked   <= 1'b1;
                            end else begin
                                good_run <= good_run + 4'd1;
                            end
                        end else begin
                            prev     <= bin_p0;
                            bin_out  <= bin_p0;
                            step_err <= 1'b1;
                            err_cnt  <= sat_inc8(err_cnt);
                            good_run <= '0;
                        end
                    end
                    default: begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
